// File: rtl/lfsr_generator.sv
// Free-running maximal-length Fibonacci LFSR.
// Q[1] is the MSB; each edge shifts toward Q[n] and feeds the tap XOR into Q[1].
// Reset and the lock-up recovery both load the seed value 1 (only Q[n] set).

`timescale 1ns / 1ps

module lfsr_generator #(
  parameter int unsigned n = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [1:n] Q
);

  // Reject widths that have no tap set.
  generate
    if (n < 2 || n > 16) begin : g_bad_width
      $fatal(1, "lfsr_generator: n must be in 2..16");
    end
  endgenerate

  // Tap positions for each width, bit t set means Q[t] feeds the XOR.
  function automatic logic [16:1] tap_mask(input int unsigned width);
    logic [16:1] m;
    m = '0;
    case (width)
      2:  begin m[2]  = 1'b1; m[1]  = 1'b1; end
      3:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
      4:  begin m[4]  = 1'b1; m[3]  = 1'b1; end
      5:  begin m[5]  = 1'b1; m[3]  = 1'b1; end
      6:  begin m[6]  = 1'b1; m[5]  = 1'b1; end
      7:  begin m[7]  = 1'b1; m[6]  = 1'b1; end
      8:  begin m[8]  = 1'b1; m[6]  = 1'b1; m[5]  = 1'b1; m[4] = 1'b1; end
      9:  begin m[9]  = 1'b1; m[5]  = 1'b1; end
      10: begin m[10] = 1'b1; m[7]  = 1'b1; end
      11: begin m[11] = 1'b1; m[9]  = 1'b1; end
      12: begin m[12] = 1'b1; m[6]  = 1'b1; m[4]  = 1'b1; m[1] = 1'b1; end
      13: begin m[13] = 1'b1; m[4]  = 1'b1; m[3]  = 1'b1; m[1] = 1'b1; end
      14: begin m[14] = 1'b1; m[5]  = 1'b1; m[3]  = 1'b1; m[1] = 1'b1; end
      15: begin m[15] = 1'b1; m[14] = 1'b1; end
      16: begin m[16] = 1'b1; m[15] = 1'b1; m[13] = 1'b1; m[4] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [16:1] TapMask = tap_mask(n);
  localparam logic [1:n]  Seed    = n'(1);

  logic [1:n] r_state;
  logic [1:n] w_next;
  logic       w_fb;

  // Feedback bit: XOR of the tapped state bits.
  always_comb begin
    w_fb = 1'b0;
    for (int unsigned i = 1; i <= n; i++) begin
      if (TapMask[i]) begin
        w_fb = w_fb ^ r_state[i];
      end
    end
  end

  // Next state: shift toward Q[n], except escape the all-zero lock-up by reseeding.
  always_comb begin
    w_next = r_state;
    if (r_state == '0) begin
      w_next = Seed;
    end else begin
      w_next[1]   = w_fb;
      w_next[2:n] = r_state[1:n-1];
    end
  end

  // State register with asynchronous seed load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= Seed;
    end else begin
      r_state <= w_next;
    end
  end

  assign Q = r_state;

endmodule

// File: tb/tb_lfsr_generator.sv
// Self-checking bench for lfsr_generator at widths 3, 4 and 16.

`timescale 1ns / 1ps

module tb_lfsr_generator;

  logic        clk = 1'b0;
  logic        rst3_n;
  logic        rstw_n;
  logic [2:0]  q3;
  logic [3:0]  q4;
  logic [15:0] q16;

  always #5 clk = ~clk;

  lfsr_generator #(.n(3)) dut3 (
    .clk     (clk),
    .reset_n (rst3_n),
    .Q       (q3)
  );

  lfsr_generator #(.n(4)) dut4 (
    .clk     (clk),
    .reset_n (rstw_n),
    .Q       (q4)
  );

  lfsr_generator #(.n(16)) dut16 (
    .clk     (clk),
    .reset_n (rstw_n),
    .Q       (q16)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    int unsigned exp;
  } sb_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[9];
  sb_t  sb_q[$];

  int unsigned cnt;
  int unsigned bad3;
  logic [7:0]  mask3;
  int unsigned p4, p16, bad4, bad16;
  bit          seen4  [16];
  bit          seen16 [65536];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input int unsigned exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_cmp(input int unsigned act);
    sb_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, act, e.exp);
    end
  endtask

  initial begin
    // Reset-edge entry, then the n=3 reference sequence 4,2,5,6,7,3,1,4.
    vecs[0] = '{1'b0, 3'd1};
    vecs[1] = '{1'b1, 3'd4};
    vecs[2] = '{1'b1, 3'd2};
    vecs[3] = '{1'b1, 3'd5};
    vecs[4] = '{1'b1, 3'd6};
    vecs[5] = '{1'b1, 3'd7};
    vecs[6] = '{1'b1, 3'd3};
    vecs[7] = '{1'b1, 3'd1};
    vecs[8] = '{1'b1, 3'd4};

    rst3_n = 1'b1;
    rstw_n = 1'b1;
    #1;
    rst3_n = 1'b0;
    rstw_n = 1'b0;
    #2;
    // Still before the first clock edge: reset must act asynchronously.
    chk("async_reset_q3", q3, 1);
    chk("async_reset_q4", q4, 1);
    chk("async_reset_q16", q16, 1);

    for (int i = 0; i < 9; i++) begin
      rst3_n = vecs[i].rst_n;
      sb_push($sformatf("seq3_step%0d", i), vecs[i].exp);
      @(posedge clk);
      #1;
      sb_pop_cmp(q3);
    end

    // Full period from a fresh reset.
    rst3_n = 1'b0;
    #1;
    rst3_n = 1'b1;
    cnt   = 0;
    bad3  = 0;
    mask3 = '0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      if (q3 == 3'd0 || mask3[q3]) bad3++;
      mask3[q3] = 1'b1;
    end while (q3 != 3'd1 && cnt < 20);
    chk("period3", cnt, 7);
    chk("visited3", mask3, 8'hFE);
    chk("zero_or_repeat3", bad3, 0);

    // Reset mid-sequence while Q = 6.
    cnt = 0;
    while (q3 != 3'd6 && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("reach6", q3, 6);
    #2;
    rst3_n = 1'b0;
    #1;
    chk("mid_reset_async", q3, 1);
    #2;
    rst3_n = 1'b1;
    sb_push("after_mid_reset", 4);
    @(posedge clk);
    #1;
    sb_pop_cmp(q3);

    // Lock-up recovery from a forced all-zero state.
    @(negedge clk);
    force dut3.r_state = 3'b000;
    #1;
    chk("forced_zero", q3, 0);
    release dut3.r_state;
    sb_push("lockup_reload", 1);
    sb_push("lockup_resume1", 4);
    sb_push("lockup_resume2", 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      sb_pop_cmp(q3);
    end

    // Wide instances have sat in reset through many edges.
    chk("q4_held_in_reset", q4, 1);
    chk("q16_held_in_reset", q16, 1);

    // Period and uniqueness for n=4 and n=16.
    rstw_n = 1'b1;
    p4    = 0;
    p16   = 0;
    bad4  = 0;
    bad16 = 0;
    cnt   = 0;
    while ((p4 == 0 || p16 == 0) && cnt < 70000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (p4 == 0) begin
        if (q4 == 4'd0 || seen4[q4]) bad4++;
        seen4[q4] = 1'b1;
        if (q4 == 4'd1) p4 = cnt;
      end
      if (p16 == 0) begin
        if (q16 == 16'd0 || seen16[q16]) bad16++;
        seen16[q16] = 1'b1;
        if (q16 == 16'd1) p16 = cnt;
      end
    end
    chk("period4", p4, 15);
    chk("period16", p16, 65535);
    chk("zero_or_repeat4", bad4, 0);
    chk("zero_or_repeat16", bad16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_generator.md
Name: lfsr_generator

Overview:
- Free-running maximal-length Fibonacci linear-feedback shift register. It produces a pseudo-random n-bit state that advances once per clock.
- Used as a lightweight pattern/sequence source (test-pattern generation, scrambling seeds, pseudo-random counters). It has no data inputs; only clock and reset.

Parameters:
- n, default 3, register width in bits; legal range 2..16. Any other value is an elaboration-time error, raised via a generate-time fatal or an invalid construct.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- Q  output  n, declared [1:n] with Q[1] the MSB  current LFSR state, driven directly from the state register (no combinational path from any input)

Interface decision (fixed): one clock, clk; reset_n is asynchronous and active-low.

Behaviour:
- Reset:
  - While reset_n = 0, Q is forced immediately (no clock needed) to the seed: Q[n] = 1, all other bits 0. Numerically, Q = 1.
  - Deassertion takes effect at the first rising clk edge after reset_n rises. No synchronizer is required inside the block.
- Shift rule, on every rising clk edge with reset_n = 1:
  - Q[i+1] <= Q[i] for i = 1..n-1.
  - Q[1] <= fb.
- Feedback: fb = XOR of the tapped bits Q[t] for the taps listed for width n (1-indexed, tap n always included). Maximal-length tap sets:
  - n=2: 2,1
  - n=3: 3,2
  - n=4: 4,3
  - n=5: 5,3
  - n=6: 6,5
  - n=7: 7,6
  - n=8: 8,6,5,4
  - n=9: 9,5
  - n=10: 10,7
  - n=11: 11,9
  - n=12: 12,6,4,1
  - n=13: 13,4,3,1
  - n=14: 14,5,3,1
  - n=15: 15,14
  - n=16: 16,15,13,4
- Period: exactly 2^n − 1 cycles. Every nonzero state is visited once per period, and the sequence returns to 1 after 2^n − 1 shifts.
- n=3 reference sequence from reset (Q as 3-bit value, Q[1] MSB): 1, 4, 2, 5, 6, 7, 3, 1, … (repeats).
- Lock-up protection:
  - The all-zero state is unreachable in normal operation.
  - If Q is ever 0 (upset, X-resolution), the next rising edge loads the seed value 1 instead of shifting.
- Reset mid-sequence: Q returns to 1 asynchronously. The sequence restarts from 1 at the first edge after release (next value 4 for n=3).
- No enable input: the register advances every cycle while out of reset.
- Single clock domain; no latches; all state bits reset.

Test Plan:
- n=3, assert reset_n=0 for 2 ns with no clock edge -> Q = 1 immediately (asynchronous).
- n=3, release reset and clock for 8 edges -> Q = 4,2,5,6,7,3,1,4 on successive edges.
- n=3, after release, wait for Q == 1 again -> exactly 7 clocks elapse; Q is never 0 and all values 1..7 appear once.
- n=3, assert reset_n mid-sequence while Q = 6 -> Q = 1 without a clock edge; first edge after release gives Q = 4.
- n=4 and n=16, run from reset -> period 15 and 65535 respectively, no repeated state within a period, Q never 0.
- n=3, force the internal state to 0 via the bench -> next edge Q = 1, after which the normal sequence resumes.
